// File: rtl/airlock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : airlock_ctrl
// Description : Two-door airlock sequencer with pump phases and Moore outputs.
//               Optional abort input enabled by defining AIRLOCK_ABORT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module airlock_ctrl #(
    parameter int unsigned PUMP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_in,
    input  logic       req_out,
    input  logic       done,
`ifdef AIRLOCK_ABORT_EN
    input  logic       abort,
`endif
    output logic       outer_open,
    output logic       inner_open,
    output logic       pump_on,
    output logic       chamber_p,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE_P   = 3'd0,
        IDLE_E   = 3'd1,
        EVAC     = 3'd2,
        PRESS    = 3'd3,
        OPEN_OUT = 3'd4,
        OPEN_IN  = 3'd5
    } state_e;

    localparam logic [7:0] c_LAST_CNT = 8'(PUMP_CYCLES - 1);

    state_e     state_q, state_d;
    logic       dir_q, dir_d;
    logic [7:0] cnt_q, cnt_d;
    logic       req_in_q, req_out_q, done_q;
    logic       w_ev_in, w_ev_out, w_ev_done, w_ev_abort;

    // Events are decided on the same edge they are seen: raw input vs last sample.
    assign w_ev_in   = req_in  & ~req_in_q;
    assign w_ev_out  = req_out & ~req_out_q;
    assign w_ev_done = done    & ~done_q;

`ifdef AIRLOCK_ABORT_EN
    logic abort_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= abort;
        end
    end

    assign w_ev_abort = abort & ~abort_q;
`else
    assign w_ev_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE_P;
            dir_q     <= 1'b0;
            cnt_q     <= 8'd0;
            req_in_q  <= 1'b0;
            req_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            req_in_q  <= req_in;
            req_out_q <= req_out;
            done_q    <= done;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE_P: begin
                if (w_ev_out) begin
                    state_d = OPEN_IN;
                    dir_d   = 1'b0;
                end else if (w_ev_in) begin
                    state_d = EVAC;
                    dir_d   = 1'b1;
                    cnt_d   = 8'd0;
                end
            end
            IDLE_E: begin
                if (w_ev_in) begin
                    state_d = OPEN_OUT;
                    dir_d   = 1'b1;
                end else if (w_ev_out) begin
                    state_d = PRESS;
                    dir_d   = 1'b0;
                    cnt_d   = 8'd0;
                end
            end
            EVAC: begin
                // Abort re-pressurises and ends the trip on the inner side.
                if (w_ev_abort) begin
                    state_d = PRESS;
                    dir_d   = 1'b1;
                    cnt_d   = 8'd0;
                end else if (cnt_q == c_LAST_CNT) begin
                    state_d = OPEN_OUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PRESS: begin
                if (cnt_q == c_LAST_CNT) begin
                    state_d = OPEN_IN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            OPEN_OUT: begin
                if (w_ev_done) begin
                    if (dir_q) begin
                        state_d = PRESS;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = IDLE_E;
                    end
                end
            end
            OPEN_IN: begin
                if (w_ev_done) begin
                    if (dir_q) begin
                        state_d = IDLE_P;
                    end else begin
                        state_d = EVAC;
                        cnt_d   = 8'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE_P;
                cnt_d   = 8'd0;
            end
        endcase
    end

    assign outer_open = (state_q == OPEN_OUT);
    assign inner_open = (state_q == OPEN_IN);
    assign pump_on    = (state_q == EVAC) || (state_q == PRESS);
    assign chamber_p  = (state_q == IDLE_P) || (state_q == OPEN_IN);
    assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_airlock_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_airlock_ctrl
// Description : Directed self-checking bench for airlock_ctrl, PUMP_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_airlock_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_in, req_out, done;
`ifdef AIRLOCK_ABORT_EN
    logic       abort;
`endif
    logic       outer_open, inner_open, pump_on, chamber_p;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    airlock_ctrl #(.PUMP_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .req_out   (req_out),
        .done      (done),
`ifdef AIRLOCK_ABORT_EN
        .abort     (abort),
`endif
        .outer_open(outer_open),
        .inner_open(inner_open),
        .pump_on   (pump_on),
        .chamber_p (chamber_p),
        .state     (state)
    );

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_state(input string tag, input int exp_s, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq(tag, int'(state), exp_s);
        end
    endtask

    task automatic check_outs(input string tag, input int oo, input int io, input int pu, input int cp);
        check_eq({tag, ".outer"}, int'(outer_open), oo);
        check_eq({tag, ".inner"}, int'(inner_open), io);
        check_eq({tag, ".pump"},  int'(pump_on),    pu);
        check_eq({tag, ".champ"}, int'(chamber_p),  cp);
    endtask

    task automatic pulse_done(input string tag, input int exp_s);
        done = 1'b1;
        tick();
        done = 1'b0;
        check_eq(tag, int'(state), exp_s);
    endtask

    // Doors must never be commanded open together.
    always @(negedge clk) begin
        check_eq("door_excl", int'(outer_open & inner_open), 0);
    end

    initial begin
        rst     = 1'b0;
        req_in  = 1'b0;
        req_out = 1'b0;
        done    = 1'b0;
`ifdef AIRLOCK_ABORT_EN
        abort   = 1'b0;
`endif
        #12;
        check_eq("rst.state", int'(state), 0);
        check_outs("rst", 0, 0, 0, 1);
        tick();
        rst = 1'b1;
        tick_state("idle", 0, 2);

        // Inbound trip: IDLE_P -> EVAC x4 -> OPEN_OUT -> PRESS x4 -> OPEN_IN -> IDLE_P
        req_in = 1'b1;
        tick();
        req_in = 1'b0;
        check_eq("s1.evac", int'(state), 2);
        check_outs("s1.evac", 0, 0, 1, 0);
        tick_state("s1.evac", 2, 3);
        tick_state("s1.oout", 4, 1);
        check_outs("s1.oout", 1, 0, 0, 0);
        pulse_done("s1.press", 3);
        check_outs("s1.press", 0, 0, 1, 0);
        tick_state("s1.press", 3, 3);
        tick_state("s1.oin", 5, 1);
        check_outs("s1.oin", 0, 1, 0, 1);
        pulse_done("s1.idle", 0);
        check_outs("s1.idle", 0, 0, 0, 1);

        // done outside open states is ignored
        pulse_done("idle.done", 0);
        tick_state("idle.done", 0, 1);

        // Both requests together in IDLE_P: req_out wins, outbound trip
        req_in  = 1'b1;
        req_out = 1'b1;
        tick();
        req_in  = 1'b0;
        req_out = 1'b0;
        check_eq("s2.oin", int'(state), 5);
        pulse_done("s2.evac", 2);
        tick_state("s2.evac", 2, 3);
        tick_state("s2.oout", 4, 1);
        pulse_done("s2.idle_e", 1);
        check_outs("s2.idle_e", 0, 0, 0, 0);

        // IDLE_E: req_out alone starts a pressurise, round trip back to IDLE_E
        req_out = 1'b1;
        tick();
        req_out = 1'b0;
        check_eq("s3.press", int'(state), 3);
        tick_state("s3.press", 3, 3);
        tick_state("s3.oin", 5, 1);
        pulse_done("s3.evac", 2);
        tick_state("s3.evac", 2, 3);
        tick_state("s3.oout", 4, 1);
        pulse_done("s3.idle_e", 1);

        // IDLE_E: both together, req_in wins -> OPEN_OUT inbound
        req_in  = 1'b1;
        req_out = 1'b1;
        tick();
        req_in  = 1'b0;
        req_out = 1'b0;
        check_eq("s4.oout", int'(state), 4);
        pulse_done("s4.press", 3);
        tick_state("s4.press", 3, 3);
        tick_state("s4.oin", 5, 1);
        pulse_done("s4.idle", 0);

        // req_in held 20 cycles starts one sequence; req_out pulse in EVAC ignored
        req_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            req_out = (i == 2);
            tick();
            check_eq("s5.hold", int'(state), (i <= 4) ? 2 : 4);
        end
        req_in  = 1'b0;
        req_out = 1'b0;
        pulse_done("s5.press", 3);
        tick_state("s5.press", 3, 3);
        tick_state("s5.oin", 5, 1);
        pulse_done("s5.idle", 0);

        // Reset at EVAC cycle 2 abandons the sequence; held req_in re-triggers
        req_in = 1'b1;
        tick();
        check_eq("s6.evac1", int'(state), 2);
        tick();
        check_eq("s6.evac2", int'(state), 2);
        rst = 1'b0;
        #1;
        check_eq("s6.rst", int'(state), 0);
        check_outs("s6.rst", 0, 0, 0, 1);
        tick_state("s6.rst", 0, 1);
        rst = 1'b1;
        tick();
        check_eq("s6.rearm", int'(state), 2);
        req_in = 1'b0;
        tick_state("s6.evac", 2, 3);
        tick_state("s6.oout", 4, 1);
        pulse_done("s6.press", 3);
        tick_state("s6.press", 3, 3);
        tick_state("s6.oin", 5, 1);
        pulse_done("s6.idle", 0);

`ifdef AIRLOCK_ABORT_EN
        // Abort at EVAC cycle 2 -> PRESS x4 -> OPEN_IN -> IDLE_P
        req_in = 1'b1;
        tick();
        req_in = 1'b0;
        check_eq("s7.evac1", int'(state), 2);
        tick();
        check_eq("s7.evac2", int'(state), 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("s7.press", int'(state), 3);
        tick_state("s7.press", 3, 3);
        tick_state("s7.oin", 5, 1);
        pulse_done("s7.idle", 0);

        // Abort in OPEN_OUT is ignored
        req_in = 1'b1;
        tick();
        req_in = 1'b0;
        tick_state("s8.evac", 2, 3);
        tick_state("s8.oout", 4, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("s8.abort_ign", int'(state), 4);
        pulse_done("s8.press", 3);
        tick_state("s8.press", 3, 3);
        tick_state("s8.oin", 5, 1);
        pulse_done("s8.idle", 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
